// File: rtl/summary_seq_buffer_pkg.sv
// Shared field widths, FIFO entry layout and controller state encoding
// for the summary sequence buffer.
package summary_seq_buffer_pkg;

    localparam int JOB_LEN         = 64;
    localparam int JOB_LEN_LOG2    = 6;
    localparam int SEQ_LL_BITS     = 8;
    localparam int SEQ_ML_BITS     = 8;
    localparam int SEQ_OFFSET_BITS = 16;

    typedef struct packed {
        logic [SEQ_LL_BITS-1:0]     ll;
        logic [SEQ_ML_BITS-1:0]     ml;
        logic [SEQ_OFFSET_BITS-1:0] offset;
        logic                       delim;
        logic                       eoj;
        logic [SEQ_ML_BITS-1:0]     overlap_len;
    } seq_entry_t;

    localparam int ENTRY_W = $bits(seq_entry_t);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } buf_state_t;

endpackage

// File: rtl/summary_seq_buffer_mem.sv
// DEPTH-entry register array: one synchronous write port, one
// asynchronous read port. Contents are not reset.
module sync_fifo_mem #(
    parameter int DEPTH = 8,
    parameter int W     = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/summary_seq_buffer.sv
// Buffers match summaries into a FIFO, grants upstream issue credits and
// tracks end-of-job entries so issuing pauses until the job drains.
module summary_seq_buffer
    import summary_seq_buffer_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int PIPE_LAT = 5
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_issue,
    input  logic                       i_summary_done,
    input  logic [JOB_LEN_LOG2-1:0]    i_seq_head_ptr,
    input  logic [SEQ_LL_BITS-1:0]     i_summary_ll,
    input  logic [SEQ_ML_BITS-1:0]     i_summary_ml,
    input  logic [SEQ_OFFSET_BITS-1:0] i_summary_offset,
    input  logic                       i_summary_delim,
    input  logic                       i_summary_eoj,
    input  logic [SEQ_ML_BITS-1:0]     i_summary_overlap_len,
    input  logic                       i_move_to_next_job,
    input  logic [JOB_LEN_LOG2-1:0]    i_move_forward,
    output logic                       o_issue_ok,
    output logic                       o_head_valid,
    output logic [JOB_LEN_LOG2-1:0]    o_next_seq_head_ptr,
    output logic                       o_job_done,
    output logic                       o_seq_valid,
    input  logic                       i_seq_ready,
    output logic [SEQ_LL_BITS-1:0]     o_seq_ll,
    output logic [SEQ_ML_BITS-1:0]     o_seq_ml,
    output logic [SEQ_OFFSET_BITS-1:0] o_seq_offset,
    output logic                       o_seq_delim,
    output logic                       o_seq_eoj,
    output logic [SEQ_ML_BITS-1:0]     o_seq_overlap_len,
    output logic                       o_overflow_err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT   = (AW+1)'(DEPTH);
    localparam logic [AW+1:0] CREDIT_MAX = (AW+2)'(DEPTH);

    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 || PIPE_LAT < 1) begin : g_param_check
        $error("summary_seq_buffer: DEPTH must be a power of two >= 4, PIPE_LAT >= 1");
    end

    logic [AW-1:0]    wptr, rptr;
    logic [AW:0]      occ, inflight, pend_eoj;
    logic [AW+1:0]    credit_used;
    logic             full, pop, push_acc, push_eoj, pop_eoj;
    buf_state_t       state, state_nxt;
    seq_entry_t       wr_entry, head;
    logic [ENTRY_W-1:0] head_raw;

    assign wr_entry = '{ll: i_summary_ll, ml: i_summary_ml, offset: i_summary_offset,
                        delim: i_summary_delim, eoj: i_summary_eoj,
                        overlap_len: i_summary_overlap_len};

    assign full        = (occ == FULL_CNT);
    assign o_seq_valid = (occ != '0);
    assign pop         = o_seq_valid & i_seq_ready;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign push_acc    = i_summary_done & (~full | pop);
    assign push_eoj    = push_acc & i_summary_eoj;
    assign pop_eoj     = pop & head.eoj;

    sync_fifo_mem #(.DEPTH(DEPTH), .W(ENTRY_W)) u_mem (
        .clk   (clk),
        .we    (push_acc),
        .waddr (wptr),
        .wdata (wr_entry),
        .raddr (rptr),
        .rdata (head_raw)
    );

    assign head              = seq_entry_t'(head_raw);
    assign o_seq_ll          = head.ll;
    assign o_seq_ml          = head.ml;
    assign o_seq_offset      = head.offset;
    assign o_seq_delim       = head.delim;
    assign o_seq_eoj         = head.eoj;
    assign o_seq_overlap_len = head.overlap_len;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr           <= '0;
            rptr           <= '0;
            occ            <= '0;
            inflight       <= '0;
            pend_eoj       <= '0;
            o_overflow_err <= 1'b0;
            o_job_done     <= 1'b0;
        end else begin
            if (push_acc) wptr <= wptr + 1'b1;
            if (pop)      rptr <= rptr + 1'b1;
            occ      <= occ + (AW+1)'(push_acc) - (AW+1)'(pop);
            pend_eoj <= pend_eoj + (AW+1)'(push_eoj) - (AW+1)'(pop_eoj);
            if (i_summary_done && full && !pop) o_overflow_err <= 1'b1;
            o_job_done <= pop_eoj;
            // Summaries retire credits; never wrap below zero on a stray done.
            case ({i_issue, i_summary_done})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   if (inflight != '0) inflight <= inflight - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_head_valid        <= 1'b0;
            o_next_seq_head_ptr <= '0;
        end else begin
            o_head_valid <= i_summary_done;
            if (i_summary_done)
                o_next_seq_head_ptr <= i_move_to_next_job ? '0 : i_seq_head_ptr + i_move_forward;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_RUN;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:   if (push_eoj) state_nxt = ST_DRAIN;
            // Leave only when the last outstanding eoj entry is popped.
            ST_DRAIN: if (pop_eoj && !push_eoj && pend_eoj == (AW+1)'(1)) state_nxt = ST_RUN;
            default:  state_nxt = ST_RUN;
        endcase
    end

    assign credit_used = (AW+2)'(occ) + (AW+2)'(inflight);
    assign o_issue_ok  = (state == ST_RUN) && (credit_used < CREDIT_MAX);

endmodule

// File: tb/tb_summary_seq_buffer.sv
// Directed plus random bench for summary_seq_buffer, checked against a
// queue-based reference model of the buffer's observable behaviour.
module tb_summary_seq_buffer;
    import summary_seq_buffer_pkg::*;

    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                       i_issue = 0, i_summary_done = 0, i_summary_delim = 0, i_summary_eoj = 0;
    logic                       i_move_to_next_job = 0, i_seq_ready = 0;
    logic [JOB_LEN_LOG2-1:0]    i_seq_head_ptr = '0, i_move_forward = '0;
    logic [SEQ_LL_BITS-1:0]     i_summary_ll = '0;
    logic [SEQ_ML_BITS-1:0]     i_summary_ml = '0, i_summary_overlap_len = '0;
    logic [SEQ_OFFSET_BITS-1:0] i_summary_offset = '0;
    logic                       o_issue_ok, o_head_valid, o_job_done, o_seq_valid;
    logic                       o_seq_delim, o_seq_eoj, o_overflow_err;
    logic [JOB_LEN_LOG2-1:0]    o_next_seq_head_ptr;
    logic [SEQ_LL_BITS-1:0]     o_seq_ll;
    logic [SEQ_ML_BITS-1:0]     o_seq_ml, o_seq_overlap_len;
    logic [SEQ_OFFSET_BITS-1:0] o_seq_offset;

    summary_seq_buffer #(.DEPTH(DEPTH), .PIPE_LAT(5)) dut (
        .clk(clk), .rst_n(rst_n), .i_issue(i_issue), .i_summary_done(i_summary_done),
        .i_seq_head_ptr(i_seq_head_ptr), .i_summary_ll(i_summary_ll), .i_summary_ml(i_summary_ml),
        .i_summary_offset(i_summary_offset), .i_summary_delim(i_summary_delim),
        .i_summary_eoj(i_summary_eoj), .i_summary_overlap_len(i_summary_overlap_len),
        .i_move_to_next_job(i_move_to_next_job), .i_move_forward(i_move_forward),
        .o_issue_ok(o_issue_ok), .o_head_valid(o_head_valid),
        .o_next_seq_head_ptr(o_next_seq_head_ptr), .o_job_done(o_job_done),
        .o_seq_valid(o_seq_valid), .i_seq_ready(i_seq_ready), .o_seq_ll(o_seq_ll),
        .o_seq_ml(o_seq_ml), .o_seq_offset(o_seq_offset), .o_seq_delim(o_seq_delim),
        .o_seq_eoj(o_seq_eoj), .o_seq_overlap_len(o_seq_overlap_len),
        .o_overflow_err(o_overflow_err)
    );

    typedef struct { int ll; int ml; int off; int delim; int eoj; int ovl; } ent_t;

    ent_t q[$];
    int   m_inflight, m_pend, m_ptr;
    bit   m_ovf, m_hv, m_jd;
    int   checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit exp_issue_ok();
        return (m_pend == 0) && (q.size() + m_inflight < DEPTH);
    endfunction

    task automatic model_reset();
        q.delete();
        m_inflight = 0; m_pend = 0; m_ptr = 0;
        m_ovf = 0; m_hv = 0; m_jd = 0;
    endtask

    task automatic check_outputs();
        chk("seq_valid", o_seq_valid, q.size() > 0);
        if (q.size() > 0) begin
            chk("seq_ll", o_seq_ll, q[0].ll);
            chk("seq_ml", o_seq_ml, q[0].ml);
            chk("seq_offset", o_seq_offset, q[0].off);
            chk("seq_delim", o_seq_delim, q[0].delim);
            chk("seq_eoj", o_seq_eoj, q[0].eoj);
            chk("seq_overlap", o_seq_overlap_len, q[0].ovl);
        end
        chk("issue_ok", o_issue_ok, exp_issue_ok());
        chk("head_valid", o_head_valid, m_hv);
        chk("head_ptr", o_next_seq_head_ptr, m_ptr);
        chk("job_done", o_job_done, m_jd);
        chk("overflow_err", o_overflow_err, m_ovf);
    endtask

    task automatic model_step();
        ent_t e;
        bit full, pop, acc;
        full = (q.size() == DEPTH);
        pop  = (q.size() > 0) && i_seq_ready;
        acc  = i_summary_done && (!full || pop);
        m_jd = 0;
        if (pop) begin
            if (q[0].eoj != 0) begin m_jd = 1; m_pend--; end
            void'(q.pop_front());
        end
        if (acc) begin
            e.ll = int'(i_summary_ll); e.ml = int'(i_summary_ml); e.off = int'(i_summary_offset);
            e.delim = int'(i_summary_delim); e.eoj = int'(i_summary_eoj);
            e.ovl = int'(i_summary_overlap_len);
            q.push_back(e);
            if (i_summary_eoj) m_pend++;
        end
        if (i_summary_done && !acc) m_ovf = 1;
        if (i_issue && !i_summary_done) m_inflight++;
        else if (!i_issue && i_summary_done && m_inflight > 0) m_inflight--;
        m_hv = i_summary_done;
        if (i_summary_done)
            m_ptr = i_move_to_next_job ? 0 : (int'(i_seq_head_ptr) + int'(i_move_forward)) % JOB_LEN;
    endtask

    // Check at the falling edge, advance the model, then step past the rising edge.
    task automatic cycle();
        @(negedge clk);
        if (!rst_n) model_reset();
        check_outputs();
        if (rst_n) model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic summ(input int ll, input int ml, input int off, input int eo);
        i_summary_done = 1;
        i_summary_ll = SEQ_LL_BITS'(ll);
        i_summary_ml = SEQ_ML_BITS'(ml);
        i_summary_offset = SEQ_OFFSET_BITS'(off);
        i_summary_eoj = eo[0];
        i_summary_delim = ll[0];
        i_summary_overlap_len = SEQ_ML_BITS'(ml >> 1);
    endtask

    task automatic idle();
        i_issue = 0; i_summary_done = 0; i_summary_eoj = 0; i_move_to_next_job = 0;
    endtask

    task automatic summ_rand(input int eo);
        summ($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 65535), eo);
    endtask

    initial begin
        model_reset();
        // Reset state
        repeat (2) cycle();
        rst_n = 1;
        cycle();

        // Three issues then three identical summaries, consumer always ready
        i_seq_ready = 1;
        repeat (3) begin i_issue = 1; cycle(); end
        i_issue = 0;
        repeat (3) begin summ(5, 8, 100, 0); cycle(); end
        idle();
        repeat (3) cycle();

        // Credit exhaustion, then a forced ninth summary onto the full FIFO
        i_seq_ready = 0;
        repeat (8) begin i_issue = 1; cycle(); end
        i_issue = 0;
        chk("credits_exhausted", o_issue_ok, 0);
        repeat (8) begin summ_rand(0); cycle(); end
        chk("no_overflow_at_full", o_overflow_err, 0);
        summ(1, 2, 3, 0); cycle();
        idle(); cycle();
        chk("overflow_sticky", o_overflow_err, 1);
        i_seq_ready = 1;
        repeat (9) cycle();

        rst_n = 0; cycle(); rst_n = 1; cycle();

        // Full FIFO with simultaneous push and pop
        i_seq_ready = 0;
        repeat (8) begin summ_rand(0); cycle(); end
        i_seq_ready = 1; summ(77, 66, 555, 0); cycle();
        idle(); i_seq_ready = 0; cycle();
        i_seq_ready = 1;
        repeat (9) cycle();

        // Head-pointer feedback: wrap and move-to-next-job
        i_seq_head_ptr = JOB_LEN_LOG2'(JOB_LEN - 4); i_move_forward = JOB_LEN_LOG2'(6);
        summ(9, 9, 9, 0); cycle();
        chk("head_ptr_wrap", o_next_seq_head_ptr, 2);
        idle(); cycle();
        i_move_to_next_job = 1; summ(4, 4, 4, 0); cycle();
        chk("head_ptr_next_job", o_next_seq_head_ptr, 0);
        idle(); repeat (2) cycle();

        // eoj behind two entries, then two eojs back to back
        i_seq_ready = 0;
        summ_rand(0); cycle(); summ_rand(0); cycle(); summ_rand(1); cycle();
        idle(); cycle();
        chk("drain_blocks_issue", o_issue_ok, 0);
        i_seq_ready = 1;
        repeat (4) cycle();
        i_seq_ready = 0;
        summ_rand(1); cycle(); summ_rand(1); cycle(); summ_rand(0); cycle();
        idle(); i_seq_ready = 1;
        repeat (5) cycle();

        // Mid-operation reset with 5 queued and 2 in flight
        i_seq_ready = 0;
        repeat (7) begin i_issue = 1; cycle(); end
        i_issue = 0;
        repeat (5) begin summ_rand(0); cycle(); end
        idle(); cycle();
        rst_n = 0;
        #1;
        chk("async_rst_valid", o_seq_valid, 0);
        chk("async_rst_issue_ok", o_issue_ok, 1);
        cycle();
        rst_n = 1;
        cycle();

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            i_issue = exp_issue_ok() && ($urandom_range(0, 1) == 1);
            i_summary_done = 0; i_summary_eoj = 0;
            if ($urandom_range(0, 2) == 0) summ_rand(($urandom_range(0, 9) == 0) ? 1 : 0);
            i_move_to_next_job = ($urandom_range(0, 3) == 0);
            i_seq_head_ptr = JOB_LEN_LOG2'($urandom_range(0, JOB_LEN - 1));
            i_move_forward = JOB_LEN_LOG2'($urandom_range(0, JOB_LEN - 1));
            i_seq_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        idle(); i_seq_ready = 1;
        repeat (12) cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
